// File: rtl/tt_digit_counter.sv
// Two-digit up/down counter with tick prescaler.
// Feeds ones/tens digits to the dual 7-segment decoder.
module tt_digit_counter #(
  parameter int CLK_DIV = 10_000_000,
  parameter int RADIX   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       up_down,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] number1,
  output logic [3:0] number2,
  output logic       tick_o,
  output logic       wrap_o
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [3:0] DMAX = 4'(RADIX - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("tt_digit_counter: CLK_DIV must be >= 2");
  end

  if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
    $error("tt_digit_counter: RADIX must be 10 or 16");
  end

  logic [PW-1:0] pre;
  logic          step;
  logic [3:0]    ones_s;
  logic [3:0]    tens_s;
  logic          wrap_s;
  logic [3:0]    ld_ones;
  logic [3:0]    ld_tens;

  // Loaded nibbles outside the radix saturate at the top digit.
  function automatic logic [3:0] clamp(input logic [3:0] d);
    return (d > DMAX) ? DMAX : d;
  endfunction

  assign ld_ones = clamp(load_val[3:0]);
  assign ld_tens = clamp(load_val[7:4]);

  // Step fires on the prescaler rollover edge.
  assign step = run && (pre == PMAX);

  // Next digit pair for a step, with carry/borrow into tens.
  always_comb begin
    ones_s = number1;
    tens_s = number2;
    wrap_s = 1'b0;
    if (up_down) begin
      if (number1 < DMAX) begin
        ones_s = number1 + 4'd1;
      end else begin
        ones_s = 4'd0;
        if (number2 < DMAX) begin
          tens_s = number2 + 4'd1;
        end else begin
          tens_s = 4'd0;
          wrap_s = 1'b1;
        end
      end
    end else begin
      if (number1 > 4'd0) begin
        ones_s = number1 - 4'd1;
      end else begin
        ones_s = DMAX;
        if (number2 > 4'd0) begin
          tens_s = number2 - 4'd1;
        end else begin
          tens_s = DMAX;
          wrap_s = 1'b1;
        end
      end
    end
  end

  // State: reset > clr > load > step > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre     <= '0;
      number1 <= 4'd0;
      number2 <= 4'd0;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else if (clr) begin
      pre     <= '0;
      number1 <= 4'd0;
      number2 <= 4'd0;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else if (load) begin
      pre     <= '0;
      number1 <= ld_ones;
      number2 <= ld_tens;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else if (step) begin
      pre     <= '0;
      number1 <= ones_s;
      number2 <= tens_s;
      tick_o  <= 1'b1;
      wrap_o  <= wrap_s;
    end else if (run) begin
      pre     <= pre + PONE;
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end else begin
      tick_o  <= 1'b0;
      wrap_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_digit_counter.sv
// Directed bench for tt_digit_counter.
// BCD and hex instances share all inputs.
module tb_tt_digit_counter;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       up_down;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] n1, n2, h1, h2;
  logic       tick, wrap, htick, hwrap;

  int total = 0;
  int bad   = 0;

  tt_digit_counter #(.CLK_DIV(4), .RADIX(10)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .up_down(up_down),
    .clr(clr), .load(load), .load_val(load_val),
    .number1(n1), .number2(n2), .tick_o(tick), .wrap_o(wrap)
  );

  tt_digit_counter #(.CLK_DIV(4), .RADIX(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .run(run), .up_down(up_down),
    .clr(clr), .load(load), .load_val(load_val),
    .number1(h1), .number2(h2), .tick_o(htick), .wrap_o(hwrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; up_down = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = 8'h00;
    cyc(2);
    chk("rst_n1", 32'(n1), 0);
    chk("rst_n2", 32'(n2), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);

    // 1: count up from reset, one step per 4 cycles
    rst_n = 1'b1;
    run = 1'b1;
    cyc(3);
    chk("t1_pre_tick", 32'(tick), 0);
    chk("t1_pre_val", 32'({n2, n1}), 32'h00);
    cyc(1);
    chk("t1_tick1", 32'(tick), 1);
    chk("t1_val1", 32'({n2, n1}), 32'h01);
    for (int k = 2; k <= 10; k++) begin
      cyc(1);
      chk("t1_pulse", 32'(tick), 0);
      cyc(2);
      chk("t1_gap", 32'(tick), 0);
      cyc(1);
      chk("t1_tick", 32'(tick), 1);
      chk("t1_val", 32'({n2, n1}), (k == 10) ? 32'h10 : 32'(k));
      chk("t1_nowrap", 32'(wrap), 0);
    end

    // 2: 98 -> 99 -> 00 with wrap
    do_load(8'h98);
    chk("t2_load", 32'({n2, n1}), 32'h98);
    chk("t2_ld_tick", 32'(tick), 0);
    cyc(4);
    chk("t2_99", 32'({n2, n1}), 32'h99);
    chk("t2_99_wrap", 32'(wrap), 0);
    cyc(4);
    chk("t2_00", 32'({n2, n1}), 32'h00);
    chk("t2_wrap", 32'(wrap), 1);
    chk("t2_tick", 32'(tick), 1);
    cyc(1);
    chk("t2_wrap_off", 32'(wrap), 0);

    // 3: count down through zero
    up_down = 1'b0;
    do_load(8'h00);
    cyc(4);
    chk("t3_99", 32'({n2, n1}), 32'h99);
    chk("t3_wrap", 32'(wrap), 1);
    cyc(4);
    chk("t3_98", 32'({n2, n1}), 32'h98);
    chk("t3_nowrap", 32'(wrap), 0);
    chk("t3_tick", 32'(tick), 1);

    // 4: clamping vs hex radix
    up_down = 1'b1;
    do_load(8'hC7);
    chk("t4_clampC7", 32'({n2, n1}), 32'h97);
    do_load(8'hFA);
    chk("t4_clampFA", 32'({n2, n1}), 32'h99);
    chk("t4_hexFA", 32'({h2, h1}), 32'hFA);
    for (int k = 1; k <= 5; k++) begin
      cyc(4);
      chk("t4_hex", 32'({h2, h1}), 32'hFA + 32'(k));
      chk("t4_hex_tick", 32'(htick), 1);
      chk("t4_hex_nowrap", 32'(hwrap), 0);
    end
    cyc(4);
    chk("t4_hex00", 32'({h2, h1}), 32'h00);
    chk("t4_hex_wrap", 32'(hwrap), 1);

    // 5: pause mid-prescale
    do_load(8'h23);
    cyc(2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("t5_hold_tick", 32'(tick), 0);
      chk("t5_hold_val", 32'({n2, n1}), 32'h23);
    end
    run = 1'b1;
    cyc(1);
    chk("t5_res_tick0", 32'(tick), 0);
    cyc(1);
    chk("t5_res_tick1", 32'(tick), 1);
    chk("t5_res_val", 32'({n2, n1}), 32'h24);

    // 6: clr beats load; reset mid-count
    clr = 1'b1;
    load = 1'b1;
    load_val = 8'h55;
    cyc(1);
    clr = 1'b0;
    load = 1'b0;
    chk("t6_clr", 32'({n2, n1}), 32'h00);
    chk("t6_clr_tick", 32'(tick), 0);
    do_load(8'h37);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    chk("t6_rst_val", 32'({n2, n1}), 32'h00);
    chk("t6_rst_tick", 32'(tick), 0);
    rst_n = 1'b1;
    cyc(4);
    chk("t6_after_tick", 32'(tick), 1);
    chk("t6_after_val", 32'({n2, n1}), 32'h01);

    // load on the rollover edge suppresses the step
    cyc(3);
    do_load(8'h42);
    chk("t7_ld_val", 32'({n2, n1}), 32'h42);
    chk("t7_ld_tick", 32'(tick), 0);
    cyc(3);
    chk("t7_gap", 32'(tick), 0);
    cyc(1);
    chk("t7_step", 32'({n2, n1}), 32'h43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
